// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//   Sequencing FSM for a multi-cycle RV32I core whose datapath shares a single
//   instruction/data memory port.  Each instruction walks through
//   FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB).  The block drives the datapath
//   strobes, supervises the memory ready handshake with a timeout, traps on
//   illegal opcodes and counts retired instructions.
//
// State table:
//   state   | code | meaning
//   IDLE    | 0    | first cycle out of reset, no strobes
//   FETCH   | 1    | read instruction at PC, load IR and PC+4 on mem_ready
//   DECODE  | 2    | opcode check, register operands settle
//   EXECUTE | 3    | ALU operation, branch/jump PC update
//   MEM     | 4    | load/store access at ALU address
//   WB      | 5    | register-file writeback, instruction retires
//   TRAP    | 7    | illegal opcode or memory timeout; left only by reset
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   instruction   in   IR contents, opcode in [6:0]
//   mem_ready     in   memory completes the current request
//   branch_taken  in   branch compare result, valid in EXECUTE
//   memReq/memWe/iOrD                memory port controls
//   irWrite/pcWrite/pcSrc            IR and PC update controls
//   aluSrc/aluOp                     ALU operand/operation select
//   regWrite/memToReg                writeback controls
//   retire        out  one-cycle pulse per completed instruction
//   instret       out  retired-instruction counter (wraps)
//   state         out  current state, for debug
//   illegal       out  sticky illegal-opcode flag
//   mem_fault     out  sticky memory-timeout flag
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        memReq,
    output logic        memWe,
    output logic        iOrD,
    output logic        irWrite,
    output logic        pcWrite,
    output logic [1:0]  pcSrc,
    output logic        aluSrc,
    output logic [1:0]  aluOp,
    output logic        regWrite,
    output logic [1:0]  memToReg,
    output logic        retire,
    output logic [31:0] instret,
    output logic [2:0]  state,
    output logic        illegal,
    output logic        mem_fault
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_TRAP    = 3'd7
    } state_t;

    localparam logic [7:0] LP_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_wait;
    logic [31:0] r_instret;
    logic        r_illegal;
    logic        r_mem_fault;

    logic        w_set_illegal;
    logic        w_set_fault;
    logic        w_timeout;
    logic [6:0]  w_opcode;
    logic        w_is_i, w_is_l, w_is_r, w_is_s, w_is_sb, w_is_u, w_is_uj;
    logic        w_legal;
    logic        w_unused_instr;

    assign w_opcode = instruction[6:0];
    assign w_unused_instr = ^instruction[31:7];

    assign w_is_i  = (w_opcode == 7'b0010011);
    assign w_is_l  = (w_opcode == 7'b0000011);
    assign w_is_r  = (w_opcode == 7'b0110011);
    assign w_is_s  = (w_opcode == 7'b0100011);
    assign w_is_sb = (w_opcode == 7'b1100011);
    assign w_is_u  = (w_opcode == 7'b0110111);
    assign w_is_uj = (w_opcode == 7'b1101111);
    assign w_legal = w_is_i | w_is_l | w_is_r | w_is_s | w_is_sb | w_is_u | w_is_uj;

    // Fires on the MEM_TIMEOUT-th consecutive cycle without ready; a ready in
    // that same cycle still completes the access.
    assign w_timeout = (r_wait == LP_WAIT_LAST) && !mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_set_illegal = 1'b0;
        w_set_fault   = 1'b0;
        memReq        = 1'b0;
        memWe         = 1'b0;
        iOrD          = 1'b0;
        irWrite       = 1'b0;
        pcWrite       = 1'b0;
        pcSrc         = 2'b00;
        aluSrc        = 1'b0;
        aluOp         = 2'b00;
        regWrite      = 1'b0;
        memToReg      = 2'b00;
        retire        = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                memReq = 1'b1;
                if (mem_ready) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    w_next  = S_DECODE;
                end else if (w_timeout) begin
                    w_set_fault = 1'b1;
                    w_next      = S_TRAP;
                end
            end
            S_DECODE: begin
                if (w_legal) begin
                    w_next = S_EXECUTE;
                end else begin
                    w_set_illegal = 1'b1;
                    w_next        = S_TRAP;
                end
            end
            S_EXECUTE: begin
                if (w_is_i) begin
                    aluSrc = 1'b1;
                    aluOp  = 2'b01;
                    w_next = S_WB;
                end else if (w_is_l || w_is_s) begin
                    aluSrc = 1'b1;
                    aluOp  = 2'b00;
                    w_next = S_MEM;
                end else if (w_is_r) begin
                    aluSrc = 1'b0;
                    aluOp  = 2'b01;
                    w_next = S_WB;
                end else if (w_is_sb) begin
                    aluSrc  = 1'b0;
                    aluOp   = 2'b10;
                    pcWrite = branch_taken;
                    pcSrc   = 2'b01;
                    retire  = 1'b1;
                    w_next  = S_FETCH;
                end else if (w_is_u) begin
                    aluSrc = 1'b1;
                    aluOp  = 2'b11;
                    w_next = S_WB;
                end else begin
                    // UJ: the jump target is written here, rd gets PC+4 in WB.
                    aluSrc  = 1'b1;
                    aluOp   = 2'b00;
                    pcWrite = 1'b1;
                    pcSrc   = 2'b10;
                    w_next  = S_WB;
                end
            end
            S_MEM: begin
                memReq = 1'b1;
                iOrD   = 1'b1;
                memWe  = w_is_s;
                aluSrc = 1'b1;
                aluOp  = 2'b00;
                if (mem_ready) begin
                    if (w_is_s) begin
                        retire = 1'b1;
                        w_next = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_timeout) begin
                    w_set_fault = 1'b1;
                    w_next      = S_TRAP;
                end
            end
            S_WB: begin
                regWrite = 1'b1;
                retire   = 1'b1;
                w_next   = S_FETCH;
                if (w_is_l) begin
                    memToReg = 2'b00;
                end else if (w_is_uj) begin
                    memToReg = 2'b10;
                end else begin
                    memToReg = 2'b01;
                end
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_TRAP;
            end
        endcase
    end

    // Wait counter restarts whenever a new memory phase begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait <= 8'd0;
        end else if ((w_next != r_state) && ((w_next == S_FETCH) || (w_next == S_MEM))) begin
            r_wait <= 8'd0;
        end else if (memReq && !mem_ready) begin
            r_wait <= r_wait + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret   <= 32'd0;
            r_illegal   <= 1'b0;
            r_mem_fault <= 1'b0;
        end else begin
            if (retire) begin
                r_instret <= r_instret + 32'd1;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_set_fault) begin
                r_mem_fault <= 1'b1;
            end
        end
    end

    assign instret   = r_instret;
    assign state     = r_state;
    assign illegal   = r_illegal;
    assign mem_fault = r_mem_fault;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    localparam int TO = 15;

    localparam int C_I  = 0;
    localparam int C_L  = 1;
    localparam int C_R  = 2;
    localparam int C_S  = 3;
    localparam int C_SB = 4;
    localparam int C_U  = 5;
    localparam int C_UJ = 6;
    localparam int C_BAD = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instruction = 32'd0;
    logic        mem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic        memReq, memWe, iOrD, irWrite, pcWrite, aluSrc, regWrite, retire;
    logic [1:0]  pcSrc, aluOp, memToReg;
    logic [31:0] instret;
    logic [2:0]  state;
    logic        illegal, mem_fault;

    multicycle_controller #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .memReq(memReq), .memWe(memWe), .iOrD(iOrD),
        .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc), .aluSrc(aluSrc),
        .aluOp(aluOp), .regWrite(regWrite), .memToReg(memToReg), .retire(retire),
        .instret(instret), .state(state), .illegal(illegal), .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    // One expected cycle: inputs to apply and outputs to expect.
    typedef struct {
        logic [31:0] ins;
        logic        rdy;
        logic        br;
        logic [2:0]  st;
        logic [14:0] vec;
        logic        set_ill;
        logic        set_flt;
    } step_t;

    step_t       plan[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_ret = 32'd0;
    logic        exp_ill = 1'b0;
    logic        exp_flt = 1'b0;

    logic [0:0]  alusrc_tab[7];
    logic [1:0]  aluop_tab[7];
    logic [6:0]  ops[7];

    wire [14:0] obs_vec = {memReq, memWe, iOrD, irWrite, pcWrite, pcSrc, aluSrc,
                           aluOp, regWrite, memToReg, retire};

    function automatic logic [14:0] mkvec(logic mr, logic mw, logic io, logic irw,
                                          logic pcw, logic [1:0] pcs, logic as,
                                          logic [1:0] ao, logic rw, logic [1:0] m2r,
                                          logic rt);
        return {mr, mw, io, irw, pcw, pcs, as, ao, rw, m2r, rt};
    endfunction

    function automatic int cls(logic [6:0] op);
        case (op)
            7'b0010011: return C_I;
            7'b0000011: return C_L;
            7'b0110011: return C_R;
            7'b0100011: return C_S;
            7'b1100011: return C_SB;
            7'b0110111: return C_U;
            7'b1101111: return C_UJ;
            default:    return C_BAD;
        endcase
    endfunction

    function automatic step_t mkstep(logic [31:0] ins, logic rdy, logic br, logic [2:0] st,
                                     logic [14:0] vec, logic si, logic sf);
        step_t s;
        s.ins = ins; s.rdy = rdy; s.br = br; s.st = st; s.vec = vec;
        s.set_ill = si; s.set_flt = sf;
        return s;
    endfunction

    function automatic logic rbit();
        logic [31:0] r;
        r = $urandom();
        return r[0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic add_trap(input logic [31:0] ins, input int n);
        for (int i = 0; i < n; i++)
            plan.push_back(mkstep(ins, rbit(), rbit(), 3'd7, 15'd0, 1'b0, 1'b0));
    endtask

    // Expected cycle sequence of one instruction.  fw/mw: wait cycles before
    // ready in FETCH/MEM; negative means ready never comes (timeout).
    task automatic plan_instr(input logic [31:0] ins, input int fw, input int mw, input logic br);
        int    c;
        int    nf;
        int    nm;
        logic  rdy;
        c  = cls(ins[6:0]);
        nf = (fw < 0) ? TO : fw + 1;
        for (int i = 0; i < nf; i++) begin
            rdy = (fw >= 0) && (i == fw);
            plan.push_back(mkstep(ins, rdy, rbit(), 3'd1,
                mkvec(1'b1, 1'b0, 1'b0, rdy, rdy, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0),
                1'b0, (fw < 0) && (i == nf - 1)));
        end
        if (fw < 0) begin
            add_trap(ins, 5);
            return;
        end
        plan.push_back(mkstep(ins, rbit(), rbit(), 3'd2, 15'd0, c == C_BAD, 1'b0));
        if (c == C_BAD) begin
            add_trap(ins, 20);
            return;
        end
        plan.push_back(mkstep(ins, rbit(), br, 3'd3,
            mkvec(1'b0, 1'b0, 1'b0, 1'b0,
                  (c == C_SB) ? br : (c == C_UJ),
                  (c == C_SB) ? 2'd1 : ((c == C_UJ) ? 2'd2 : 2'd0),
                  alusrc_tab[c], aluop_tab[c], 1'b0, 2'd0, c == C_SB),
            1'b0, 1'b0));
        if (c == C_SB) return;
        if (c == C_L || c == C_S) begin
            nm = (mw < 0) ? TO : mw + 1;
            for (int i = 0; i < nm; i++) begin
                rdy = (mw >= 0) && (i == mw);
                plan.push_back(mkstep(ins, rdy, rbit(), 3'd4,
                    mkvec(1'b1, c == C_S, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 2'd0,
                          rdy && (c == C_S)),
                    1'b0, (mw < 0) && (i == nm - 1)));
            end
            if (mw < 0) begin
                add_trap(ins, 5);
                return;
            end
            if (c == C_S) return;
        end
        plan.push_back(mkstep(ins, rbit(), rbit(), 3'd5,
            mkvec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1,
                  (c == C_L) ? 2'd0 : ((c == C_UJ) ? 2'd2 : 2'd1), 1'b1),
            1'b0, 1'b0));
    endtask

    task automatic run_plan(input int limit);
        step_t s;
        int    n;
        n = 0;
        while (plan.size() > 0 && n < limit) begin
            s = plan.pop_front();
            n++;
            @(negedge clk);
            instruction  = s.ins;
            mem_ready    = s.rdy;
            branch_taken = s.br;
            #1;
            chk("state", 32'(state), 32'(s.st));
            chk("strobes", 32'(obs_vec), 32'(s.vec));
            chk("instret", instret, exp_ret);
            chk("illegal", 32'(illegal), 32'(exp_ill));
            chk("mem_fault", 32'(mem_fault), 32'(exp_flt));
            @(posedge clk);
            if (s.vec[0]) exp_ret = exp_ret + 32'd1;
            if (s.set_ill) exp_ill = 1'b1;
            if (s.set_flt) exp_flt = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_strobes", 32'(obs_vec), 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_fault", 32'(mem_fault), 32'd0);
        exp_ret = 32'd0;
        exp_ill = 1'b0;
        exp_flt = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mem_ready = rbit();
        #1;
        chk("idle_state", 32'(state), 32'd0);
        chk("idle_strobes", 32'(obs_vec), 32'd0);
        @(posedge clk);
    endtask

    initial begin
        logic [31:0] r;
        alusrc_tab = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        aluop_tab  = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd0};
        ops        = '{7'b0010011, 7'b0000011, 7'b0110011, 7'b0100011,
                       7'b1100011, 7'b0110111, 7'b1101111};

        do_reset();
        // Directed program
        plan_instr(32'h00500093, 0, 0, 1'b0);   // addi
        plan_instr(32'h0000A103, 0, 3, 1'b0);   // lw, ready on 4th MEM cycle
        plan_instr(32'h0020A023, 0, 0, 1'b0);   // sw
        plan_instr(32'h00208463, 0, 0, 1'b1);   // beq taken
        plan_instr(32'h00208463, 0, 0, 1'b0);   // beq not taken
        plan_instr(32'h008000EF, 0, 0, 1'b0);   // jal
        run_plan(10000);

        // Random legal program with random memory latency
        for (int k = 0; k < 40; k++) begin
            r = $urandom();
            r[6:0] = ops[$urandom_range(0, 6)];
            plan_instr(r, $urandom_range(0, 4), $urandom_range(0, 4), rbit());
        end
        plan_instr(32'h00500093, 14, 0, 1'b0);  // FETCH ready on the last allowed cycle
        plan_instr(32'h0000A103, 2, 14, 1'b0);  // MEM ready on the last allowed cycle
        run_plan(10000);

        // Illegal opcode trap
        plan_instr(32'h0000007F, 1, 0, 1'b0);
        run_plan(10000);
        do_reset();

        // FETCH timeout
        plan_instr(32'h00500093, -1, 0, 1'b0);
        run_plan(10000);
        do_reset();

        // MEM timeout
        plan_instr(32'h00500093, 0, 0, 1'b0);
        plan_instr(32'h0000A103, 0, -1, 1'b0);
        run_plan(10000);
        do_reset();

        // Reset in the middle of a store's MEM phase
        plan_instr(32'h0020A023, 0, 8, 1'b0);
        run_plan(6);
        plan.delete();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_memReq", 32'(memReq), 32'd0);
        chk("midrst_memWe", 32'(memWe), 32'd0);
        chk("midrst_state", 32'(state), 32'd0);
        do_reset();
        plan_instr(32'h0020A023, 1, 1, 1'b0);
        plan_instr(32'h00500093, 0, 0, 1'b0);
        run_plan(10000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle sequencing FSM for the RV32I core, for a datapath with one shared instruction/data memory port.
- Steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB, and drives the datapath strobes (PC, IR, register file, ALU, memory port).
- Handles the memory ready/request handshake, a memory timeout, illegal-opcode trapping, and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles memReq may wait for mem_ready before a fault trap; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instruction  in  32  IR contents; opcode is instruction[6:0], stable from DECODE until the next FETCH.
- mem_ready  in  1  memory completes the current request this cycle.
- branch_taken  in  1  branch-compare result from the datapath; valid in EXECUTE.
- memReq  out  1  memory request.
- memWe  out  1  memory write enable.
- iOrD  out  1  memory address select: 0 = PC, 1 = ALU result.
- irWrite  out  1  load IR (datapath latches oldPC on the same edge).
- pcWrite  out  1  PC update.
- pcSrc  out  2  PC source: 00 = PC+4, 01 = branch target, 10 = jump target.
- aluSrc  out  1  ALU operand B select: 0 = rs2, 1 = immediate.
- aluOp  out  2  ALU operation class.
- regWrite  out  1  register-file write.
- memToReg  out  2  writeback source: 00 = memory data, 01 = ALU result, 10 = PC+4.
- retire  out  1  one-cycle pulse when an instruction completes.
- instret  out  32  retired-instruction count; wraps modulo 2^32.
- state  out  3  current state, for debug.
- illegal  out  1  sticky; illegal opcode trapped.
- mem_fault  out  1  sticky; memory timeout trapped.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, TRAP=7.
- Reset (asynchronous, rst_n low): state=IDLE, wait counter=0, instret=0, illegal=0, mem_fault=0. All strobes 0, pcSrc=00, aluOp=00, memToReg=00.
- Strobes are combinational from the registered state, the opcode and mem_ready. Any strobe not listed for a state is 0.
- IDLE: no outputs; next state FETCH.
- FETCH: memReq=1, iOrD=0. On mem_ready: irWrite=1, pcWrite=1, pcSrc=00, next state DECODE. Otherwise stay in FETCH.
- DECODE: one cycle. Legal opcodes are 0010011, 0000011, 0110011, 0100011, 1100011, 0110111 and 1101111; a legal opcode goes to EXECUTE. Any other opcode goes to TRAP and sets illegal.
- EXECUTE, aluSrc/aluOp per opcode:
  - I-type: 1/01; L-type: 1/00; R-type: 0/01; S-type: 1/00; SB-type: 0/10; U-type: 1/11; UJ-type: 1/00.
- EXECUTE, next state per opcode:
  - L and S: MEM.
  - SB: pcWrite=branch_taken, pcSrc=01, retire=1, next state FETCH.
  - UJ: pcWrite=1, pcSrc=10, next state WB.
  - I, R and U: WB.
- MEM: memReq=1, iOrD=1, memWe=1 for S only; aluSrc=1, aluOp=00 held. On mem_ready: S sets retire=1 and goes to FETCH; L goes to WB. Otherwise stay in MEM.
- WB: regWrite=1, retire=1, next state FETCH. memToReg: L=00, I/R/U=01, UJ=10.
- Wait counter:
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle memReq=1 and mem_ready=0.
  - If mem_ready=0 when the counter equals MEM_TIMEOUT-1 (MEM_TIMEOUT cycles without ready), next state is TRAP and mem_fault is set.
  - mem_ready arriving on that same cycle wins and is accepted.
- TRAP: all strobes 0, retire=0. Only rst_n exits TRAP.
- instret: increments on the clock edge ending any cycle with retire=1.
- Reset mid-handshake: request is dropped immediately; no partial write is issued after rst_n deasserts.
- mem_ready outside FETCH/MEM is ignored.

Test Plan:
- Reset, release rst_n; addi 0x00500093, mem_ready tied 1 -> state sequence 0,1,2,3,5,1; EXECUTE aluSrc=1, aluOp=01; WB regWrite=1, memToReg=01, retire=1; instret=1.
- lw 0x0000A103, mem_ready asserted on the 4th MEM cycle -> memReq=1, iOrD=1, memWe=0 for 4 cycles; WB memToReg=00; instret +1.
- sw 0x0020A023 then beq 0x00208463 with branch_taken=1:
  - sw: MEM memWe=1, retire in MEM, no WB, regWrite never 1.
  - beq: EXECUTE pcWrite=1, pcSrc=01, retire=1, next state FETCH. Repeating with branch_taken=0 gives pcWrite=0.
- jal 0x008000EF -> EXECUTE pcWrite=1, pcSrc=10; WB regWrite=1, memToReg=10.
- Illegal 0x0000007F -> DECODE then TRAP(7), illegal=1; strobes 0 for 20 cycles; instret unchanged; asserting rst_n returns to IDLE with illegal=0.
- MEM_TIMEOUT=15, mem_ready held 0 in FETCH -> TRAP after exactly 15 FETCH cycles, mem_fault=1. Variant with mem_ready on the 15th cycle -> DECODE, no fault. rst_n pulsed mid-MEM -> memReq drops combinationally and state=0.
